// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the memory port arbiter
package mem_arb_pkg;
  localparam int N_DEF         = 8;
  localparam int AW_DEF        = 32;
  localparam int DW_DEF        = 128;
  localparam int RD_LAT_DEF    = 2;
  localparam int MAX_BURST_DEF = 4;
  typedef enum logic [2:0] {ARB, BURST, DRAIN, JTAG, DRAIN_J} state_e;
  typedef struct packed {
    logic             valid;
    logic [N_DEF-1:0] lane;
    logic             jtag;
  } rd_tag_t;
endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick: combinational N-way round-robin priority encoder
// ports: req (requests), ptr (highest-priority lane), gnt (one-hot winner)
module rr_pick #(
  parameter int N  = 8,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  logic [LW-1:0] j;
  // walk from farthest to nearest so the lane closest to ptr wins last
  always_comb begin
    gnt = '0;
    j   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = ptr + LW'(k);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between N engine lanes and JTAG
// ports: engine side Req/WrEn/Addr/WrData/Lock -> Gnt, RdValid/RdData;
//        JTAG side JtagEn/JtagRdEn/JtagWrEn/JtagAddr/JtagWrData -> JtagRdy, JtagRdValid/JtagRdData;
//        RAM side registered MemEn/MemWe/MemAddr/MemWrData, MemRdData after RD_LAT
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int RD_LAT    = RD_LAT_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int LW        = $clog2(N),
  parameter int CW        = $clog2(MAX_BURST + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         Req,
  input  logic [N-1:0]         WrEn,
  input  logic [N-1:0][AW-1:0] Addr,
  input  logic [N-1:0][DW-1:0] WrData,
  input  logic [N-1:0]         Lock,
  output logic [N-1:0]         Gnt,
  output logic [N-1:0]         RdValid,
  output logic [DW-1:0]        RdData,
  input  logic                 JtagEn,
  input  logic                 JtagRdEn,
  input  logic                 JtagWrEn,
  input  logic [AW-1:0]        JtagAddr,
  input  logic [DW-1:0]        JtagWrData,
  output logic [DW-1:0]        JtagRdData,
  output logic                 JtagRdValid,
  output logic                 JtagRdy,
  output logic                 MemEn,
  output logic                 MemWe,
  output logic [AW-1:0]        MemAddr,
  output logic [DW-1:0]        MemWrData,
  input  logic [DW-1:0]        MemRdData
);
  state_e        state, state_n;
  logic [LW-1:0] ptr, ptr_n, owner, owner_n, gidx;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0]  pick;
  logic          jtag_cmd, pend, drained;
  rd_tag_t       cmd_tag, tail;
  rd_tag_t       tag_q [RD_LAT];

  rr_pick #(.N(N), .LW(LW)) u_pick (.req(Req), .ptr(ptr), .gnt(pick));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB;
      ptr   <= '0;
      cnt   <= '0;
      owner <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      owner <= owner_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    owner_n = owner;
    case (state)
      ARB:
        if (JtagEn) state_n = DRAIN;
        else if (|Gnt) begin
          if (Lock[gidx]) begin
            state_n = BURST;
            owner_n = gidx;
            cnt_n   = CW'(1);
          end else ptr_n = gidx + 1'b1;
        end
      BURST: begin
        cnt_n = cnt + 1'b1;
        // a dropped Req ends ownership without a grant; JtagEn truncates the burst
        if (JtagEn || !Req[owner] || !Lock[owner] || cnt_n == CW'(MAX_BURST)) begin
          state_n = JtagEn ? DRAIN : ARB;
          ptr_n   = owner + 1'b1;
          cnt_n   = '0;
        end
      end
      DRAIN:   if (drained) state_n = JtagEn ? JTAG : ARB;
      JTAG:    if (!JtagEn) state_n = DRAIN_J;
      DRAIN_J: if (drained) state_n = ARB;
      default: state_n = ARB;
    endcase
  end

  always_comb begin
    Gnt = '0;
    if (!rst && !JtagEn)
      Gnt = state == ARB ? pick :
            (state == BURST && Req[owner]) ? {{(N-1){1'b0}}, 1'b1} << owner : '0;
    JtagRdy  = !rst && state == JTAG;
    jtag_cmd = JtagRdy && (JtagRdEn || JtagWrEn);
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++) if (Gnt[i]) gidx = LW'(i);
  end

  // the last tag stage returns this cycle, so it does not block the hand-over
  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) pend = pend | tag_q[i].valid;
    drained = !MemEn && !pend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      MemEn     <= 1'b0;
      MemWe     <= 1'b0;
      MemAddr   <= '0;
      MemWrData <= '0;
      cmd_tag   <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      MemEn <= |Gnt || jtag_cmd;
      MemWe <= jtag_cmd ? JtagWrEn : |Gnt && WrEn[gidx];
      if (|Gnt || jtag_cmd) begin
        MemAddr   <= jtag_cmd ? JtagAddr : Addr[gidx];
        MemWrData <= jtag_cmd ? JtagWrData : WrData[gidx];
      end
      cmd_tag.valid <= jtag_cmd ? !JtagWrEn : |Gnt && !WrEn[gidx];
      cmd_tag.lane  <= Gnt;
      cmd_tag.jtag  <= jtag_cmd;
      tag_q[0]      <= cmd_tag;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tail        = tag_q[RD_LAT-1];
  assign RdValid     = (!rst && tail.valid && !tail.jtag) ? tail.lane : '0;
  assign RdData      = |RdValid ? MemRdData : '0;
  assign JtagRdValid = !rst && tail.valid && tail.jtag;
  assign JtagRdData  = JtagRdValid ? MemRdData : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench with a behavioural arbiter/RAM model
module tb_mem_port_arbiter;
  localparam int N = 8, AW = 32, DW = 128, RD_LAT = 2, MAX_BURST = 4;
  localparam int M_ARB = 0, M_DRAIN = 1, M_JTAG = 2, M_DRAIN_J = 3;

  logic clk = 1'b0, rst;
  logic [N-1:0] Req, WrEn, Lock, Gnt, RdValid;
  logic [N-1:0][AW-1:0] Addr;
  logic [N-1:0][DW-1:0] WrData;
  logic [DW-1:0] RdData, JtagWrData, JtagRdData, MemWrData, MemRdData;
  logic JtagEn, JtagRdEn, JtagWrEn, JtagRdValid, JtagRdy, MemEn, MemWe;
  logic [AW-1:0] JtagAddr, MemAddr;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst), .Req(Req), .WrEn(WrEn), .Addr(Addr), .WrData(WrData),
    .Lock(Lock), .Gnt(Gnt), .RdValid(RdValid), .RdData(RdData), .JtagEn(JtagEn),
    .JtagRdEn(JtagRdEn), .JtagWrEn(JtagWrEn), .JtagAddr(JtagAddr),
    .JtagWrData(JtagWrData), .JtagRdData(JtagRdData), .JtagRdValid(JtagRdValid),
    .JtagRdy(JtagRdy), .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemWrData(MemWrData), .MemRdData(MemRdData)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(int i);
    return {96'h0123_4567_89AB_CDEF_0011_2233, 32'(i)};
  endfunction

  // RAM environment: 64 lines of DW bits, addressed by MemAddr[9:4]
  logic [DW-1:0] ram [64];
  bit            ram_w [64];
  logic [DW-1:0] rdp [RD_LAT];
  assign MemRdData = rdp[RD_LAT-1];
  always @(posedge clk) begin
    if (MemEn && MemWe) begin
      ram[MemAddr[9:4]]   <= MemWrData;
      ram_w[MemAddr[9:4]] <= 1'b1;
    end
    rdp[0] <= (MemEn && !MemWe) ? (ram_w[MemAddr[9:4]] ? ram[MemAddr[9:4]] : init_val(int'(MemAddr[9:4]))) : '0;
    for (int i = 1; i < RD_LAT; i++) rdp[i] <= rdp[i-1];
  end

  // reference model state
  typedef struct {int lane; bit j; logic [DW-1:0] d; int due;} ex_t;
  ex_t exq[$];
  logic [DW-1:0] mmem [64];
  int mode, mptr, owner, beats, last_iss, max_ret;
  logic [N-1:0] exp_gnt = '0;
  bit exp_rdy = 0, en = 0, tally = 0;
  int gcount [N];
  int checks = 0, errors = 0;

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic issue(bit we, logic [AW-1:0] a, logic [DW-1:0] d, int lane, bit j);
    last_iss = cyc;
    if (we) mmem[a[9:4]] = d;
    else begin
      exq.push_back('{lane, j, mmem[a[9:4]], cyc + 1 + RD_LAT});
      max_ret = cyc + 1 + RD_LAT;
    end
  endtask

  function automatic bit drained();
    return last_iss < cyc - 1 && max_ret <= cyc;
  endfunction

  // evaluates the model for the current cycle's inputs, then advances one clock
  task automatic step();
    int g;
    g = -1;
    exp_gnt = '0;
    exp_rdy = !rst && mode == M_JTAG;
    if (rst) begin
      mode = M_ARB; mptr = 0; owner = -1; beats = 0; last_iss = -10; max_ret = 0;
      exq.delete();
    end else case (mode)
      M_ARB:
        if (JtagEn) begin
          if (owner >= 0) mptr = (owner + 1) % N;
          owner = -1;
          mode = M_DRAIN;
        end else if (owner >= 0) begin
          if (Req[owner]) begin
            g = owner;
            beats++;
            if (!Lock[owner] || beats == MAX_BURST) begin mptr = (owner + 1) % N; owner = -1; end
          end else begin
            mptr = (owner + 1) % N;
            owner = -1;
          end
        end else begin
          for (int k = 0; k < N; k++) if (g < 0 && Req[(mptr + k) % N]) g = (mptr + k) % N;
          if (g >= 0) begin
            if (Lock[g]) begin owner = g; beats = 1; end
            else mptr = (g + 1) % N;
          end
        end
      M_DRAIN: if (drained()) mode = JtagEn ? M_JTAG : M_ARB;
      M_JTAG: begin
        if (JtagWrEn) issue(1, JtagAddr, JtagWrData, 0, 1);
        else if (JtagRdEn) issue(0, JtagAddr, '0, 0, 1);
        if (!JtagEn) mode = M_DRAIN_J;
      end
      default: if (drained()) mode = M_ARB;
    endcase
    if (g >= 0) begin
      exp_gnt[g] = 1'b1;
      issue(WrEn[g], Addr[g], WrData[g], g, 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic refill(int p);
    for (int i = 0; i < N; i++) begin
      if (exp_gnt[i]) Req[i] = 1'b0;
      if (!Req[i] && $urandom_range(99) < p) begin
        Req[i]    = 1'b1;
        WrEn[i]   = 1'($urandom_range(1));
        Lock[i]   = $urandom_range(3) == 0;
        Addr[i]   = AW'($urandom_range(63) * 16);
        WrData[i] = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  endtask

  // monitor: compares combinational outputs and pops read returns
  always @(negedge clk) if (en) begin
    ex_t e;
    chk("gnt", DW'(Gnt), DW'(exp_gnt));
    chk("jtag_rdy", DW'(JtagRdy), DW'(exp_rdy));
    if (tally) for (int i = 0; i < N; i++) if (Gnt[i]) gcount[i]++;
    if (RdValid != 0 || JtagRdValid) begin
      if (exq.size() == 0) chk("unexpected_return", DW'({JtagRdValid, RdValid}), '0);
      else begin
        e = exq.pop_front();
        chk("ret_tag", DW'({JtagRdValid, RdValid}), e.j ? DW'({1'b1, N'(0)}) : DW'({1'b0, N'(1) << e.lane}));
        chk("ret_data", JtagRdValid ? JtagRdData : RdData, e.d);
        chk("ret_cycle", DW'(cyc), DW'(e.due));
      end
    end else if (exq.size() != 0 && exq[0].due <= cyc) begin
      e = exq.pop_front();
      chk("ret_missing", DW'({JtagRdValid, RdValid}), e.j ? DW'({1'b1, N'(0)}) : DW'({1'b0, N'(1) << e.lane}));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    Req = '0; WrEn = '0; Lock = '0; Addr = '0; WrData = '0;
    JtagEn = 0; JtagRdEn = 0; JtagWrEn = 0; JtagAddr = '0; JtagWrData = '0; rst = 1;
    for (int i = 0; i < 64; i++) mmem[i] = init_val(i);
    for (int i = 0; i < N; i++) gcount[i] = 0;
    @(posedge clk);
    #1;
    en = 1;
    step();
    step();
    chk("rst_memen", DW'(MemEn), '0);
    chk("rst_memwe", DW'(MemWe), '0);
    chk("rst_memaddr", DW'(MemAddr), '0);
    rst = 0;
    // single lane, three back-to-back reads
    Req[2] = 1; Addr[2] = 32'h10;
    step();
    chk("t1_memen", DW'(MemEn), DW'(1));
    chk("t1_memaddr", DW'(MemAddr), DW'(32'h10));
    Addr[2] = 32'h20;
    step();
    Addr[2] = 32'h30;
    step();
    Req = '0;
    repeat (4) step();
    // all lanes requesting continuously
    Req = '1;
    tally = 1;
    repeat (16) step();
    tally = 0;
    Req = '0;
    for (int i = 0; i < N; i++) chk("rr_share", DW'(gcount[i]), DW'(2));
    repeat (5) step();
    // locked burst on lane 5 contending with lane 6
    Req[5] = 1; Lock[5] = 1; Req[6] = 1; Addr[5] = 32'h50; Addr[6] = 32'h60;
    repeat (6) begin
      step();
      if (exp_gnt[6]) Req[6] = 0;
    end
    Req = '0; Lock = '0;
    repeat (4) step();
    // JTAG takeover after two reads from lane 1
    Req[1] = 1; Addr[1] = 32'h10;
    step();
    Addr[1] = 32'h20;
    step();
    Req = '0; JtagEn = 1;
    w = 0;
    while (!JtagRdy && w < 20) begin step(); w++; end
    chk("jtag_rdy_wait", DW'(JtagRdy), DW'(1));
    JtagWrEn = 1; JtagAddr = 32'h40; JtagWrData = DW'(16'hDEAD);
    step();
    JtagWrEn = 0; JtagRdEn = 1;
    step();
    JtagRdEn = 1; JtagWrEn = 1; JtagAddr = 32'h50; JtagWrData = DW'(16'hBEEF);
    step();
    JtagWrEn = 0;
    step();
    JtagRdEn = 0;
    repeat (5) step();
    JtagEn = 0;
    repeat (8) step();
    // reset while two reads are in flight
    Req[4] = 1; Addr[4] = 32'h30;
    step();
    Addr[4] = 32'h60;
    step();
    Req = '0; rst = 1;
    step();
    rst = 0;
    chk("midrst_memen", DW'(MemEn), '0);
    chk("midrst_jtagrdy", DW'(JtagRdy), '0);
    repeat (5) step();
    Req[3] = 1; Req[6] = 1;
    step();
    refill(0);
    repeat (3) step();
    refill(0);
    repeat (3) step();
    // randomized traffic with periodic JTAG sessions and one reset
    for (int c = 0; c < 2000; c++) begin
      JtagEn     = (c % 400) >= 340;
      JtagRdEn   = $urandom_range(2) == 0;
      JtagWrEn   = $urandom_range(3) == 0;
      JtagAddr   = AW'($urandom_range(63) * 16);
      JtagWrData = {$urandom, $urandom, $urandom, $urandom};
      rst        = c == 1111;
      step();
      refill(40);
    end
    Req = '0; Lock = '0; JtagEn = 0; JtagRdEn = 0; JtagWrEn = 0;
    repeat (12) step();
    chk("queue_empty", DW'(exq.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
